branch_comp_seq: RTL and testbench
==================================

Name: branch_comp_seq

Overview:
- Parametrised, multi-cycle branch comparator for the RV32I core and wider XLEN variants.
- Takes a branch's two operands and funct3 through a valid/ready handshake and compares them CHUNK bits per cycle, starting at the MSB end.
- Returns BrEq, BrLT and a resolved BrTaken through a second valid/ready handshake.
- Replaces the single-cycle comparator where compare-path area or timing matters.

Parameters:
- XLEN, 32: operand width. Must be a multiple of CHUNK.
- CHUNK, 8: bits compared per cycle. NCHUNK = XLEN/CHUNK, which must be >= 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of any operation in flight.
- start_valid  in  1  operands and funct3 are valid.
- start_ready  out  1  block can accept a request; equals (state==IDLE).
- A_in  in  XLEN  rs1 operand.
- B_in  in  XLEN  rs2 operand.
- funct3  in  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- result_valid  out  1  result registers are valid.
- result_ready  in  1  consumer accepts the result.
- BrEq  out  1  A == B.
- BrLT  out  1  A < B; signed unless funct3[1]=1.
- BrTaken  out  1  branch condition is true for the latched funct3.
- BrIllegal  out  1  latched funct3 was 010 or 011.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, chunk index=0.
  - result_valid, BrEq, BrLT, BrTaken, BrIllegal, busy all =0; start_ready=1.
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - When start_valid && start_ready && !flush: latch A_in, B_in, funct3; set idx=0 (MSB chunk); go to CMP.
  - Unsigned mode = latched funct3[1].
- CMP, one chunk per cycle, chunk idx covering bits [XLEN-1-idx*CHUNK -: CHUNK]:
  - In signed mode, the MSB chunk is compared with its top bit inverted. All other chunks are always compared unsigned.
  - If the chunk differs: BrEq<=0, BrLT<=(a_chunk<b_chunk), go to DONE (see EARLY_EXIT_EN).
  - If the chunk is equal and idx==NCHUNK-1: BrEq<=1, BrLT<=0, go to DONE.
  - Otherwise idx<=idx+1.
- On entry to DONE, BrTaken and BrIllegal are registered together with BrEq and BrLT:
  - BEQ: BrTaken=BrEq.
  - BNE: BrTaken=!BrEq.
  - BLT and BLTU: BrTaken=BrLT.
  - BGE and BGEU: BrTaken=!BrLT.
  - funct3 010 or 011: BrTaken=0, BrIllegal=1.
- DONE:
  - result_valid=1. All result outputs are held stable until result_ready.
  - result_valid && result_ready: go to IDLE, result_valid<=0. Result outputs keep their last value but are meaningful only while result_valid=1.
- Latency: k+1 cycles from the accept edge to result_valid, where k is the index of the first differing chunk, or NCHUNK-1 if the operands are equal. Maximum is NCHUNK cycles.
- Throughput: no overlap. start_ready=0 from the accept edge until the cycle after the result handshake.
- flush, from any state:
  - Next edge: state=IDLE, result_valid=0, idx=0. Any result held in DONE is discarded.
  - flush has priority over a same-cycle accept and over a same-cycle result handshake.
- Reset mid-operation: immediate return to reset values; the latched operands are don't-care.
- NCHUNK=1 degenerates to a fixed 1-cycle latency.

Optional Feature:
- Macro: BRANCH_COMP_EARLY_EXIT_EN.
- Defined: CMP exits on the first differing chunk. Latency varies from 1 to NCHUNK.
- Undefined:
  - The first differing chunk's result is captured into a sticky decided flag.
  - Later chunks are ignored.
  - CMP always runs all NCHUNK cycles, giving a constant latency of NCHUNK.
  - Results are identical to the defined case.

Test Plan:
- BEQ, A=B=0x12345678, XLEN=32, CHUNK=8 -> result_valid after 4 cycles; BrEq=1, BrLT=0, BrTaken=1.
- BLT, A=0xFFFFFFFF, B=0x00000001 -> BrLT=1, BrTaken=1. Latency 1 with EARLY_EXIT_EN, 4 without.
- BLTU and BGEU, same operands -> BrLT=0; BLTU BrTaken=0, BGEU BrTaken=1.
- BGE, A=0x00000010, B=0x00000020 -> latency 4, BrLT=1, BrTaken=0. funct3=010 -> BrIllegal=1, BrTaken=0.
- result_ready held at 0 for 5 cycles -> outputs stable and start_ready=0 throughout. Separately, flush in CMP cycle 2 -> IDLE next cycle, result_valid never rises.
- rst_n pulled low during CMP -> all outputs 0 immediately. After release, start_ready=1 and a new BNE request with A=1, B=2 gives BrTaken=1.

Source files
------------

// File: rtl/branch_comp_seq.sv
// Multi-cycle branch comparator: walks operands CHUNK bits per cycle from the MSB end, then holds BrEq/BrLT/BrTaken until taken.
// Latency 1..NCHUNK cycles with BRANCH_COMP_EARLY_EXIT_EN defined, fixed NCHUNK otherwise; start_ready only in IDLE, result held until result_ready.
module branch_comp_seq #(
   parameter int XLEN  = 32,
   parameter int CHUNK = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            start_valid,
   output logic            start_ready,
   input  logic [XLEN-1:0] A_in,
   input  logic [XLEN-1:0] B_in,
   input  logic [2:0]      funct3,
   output logic            result_valid,
   input  logic            result_ready,
   output logic            BrEq,
   output logic            BrLT,
   output logic            BrTaken,
   output logic            BrIllegal,
   output logic            busy
);

   localparam int NCHUNK = XLEN / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

   typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

   state_t            state, stateNext;
   logic [XLEN-1:0]   aReg, bReg, aSh, bSh;
   logic [2:0]        f3Reg;
   logic [IW-1:0]     idx;
   logic [CHUNK-1:0]  aChunk, bChunk;
   logic              chunkNe, chunkLT, isFinal, resEq, resLT;
   logic              accept, finishCmp, takenNext, illNext;

   assign accept    = (state == IDLE) && start_valid && !flush;
   assign finishCmp = (state == CMP) && isFinal && !flush;

   // Bring the current chunk to the top; in signed mode flip the sign bit so an unsigned compare orders it correctly.
   always_comb begin
      aSh    = aReg << (32'(idx) * CHUNK);
      bSh    = bReg << (32'(idx) * CHUNK);
      aChunk = aSh[XLEN-1 -: CHUNK];
      bChunk = bSh[XLEN-1 -: CHUNK];
      if (idx == '0 && !f3Reg[1]) begin
         aChunk[CHUNK-1] = ~aChunk[CHUNK-1];
         bChunk[CHUNK-1] = ~bChunk[CHUNK-1];
      end
      chunkNe = (aChunk != bChunk);
      chunkLT = (aChunk < bChunk);
   end

`ifdef BRANCH_COMP_EARLY_EXIT_EN
   assign isFinal = chunkNe || (idx == LAST_IDX);
   assign resEq   = !chunkNe;
   assign resLT   = chunkLT;
`else
   logic decided, decLT;

   assign isFinal = (idx == LAST_IDX);
   assign resEq   = !decided && !chunkNe;
   assign resLT   = decided ? decLT : chunkLT;

   // The first differing chunk decides the outcome; later chunks only burn cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         decided <= 1'b0;
         decLT   <= 1'b0;
      end else if (accept || flush) begin
         decided <= 1'b0;
         decLT   <= 1'b0;
      end else if (state == CMP && !decided && chunkNe) begin
         decided <= 1'b1;
         decLT   <= chunkLT;
      end
   end
`endif

   always_comb begin
      takenNext = 1'b0;
      illNext   = 1'b0;
      case (f3Reg)
         3'b000:         takenNext = resEq;
         3'b001:         takenNext = !resEq;
         3'b100, 3'b110: takenNext = resLT;
         3'b101, 3'b111: takenNext = !resLT;
         default:        illNext   = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      if (flush) begin
         stateNext = IDLE;
      end else begin
         case (state)
            IDLE:    if (start_valid) stateNext = CMP;
            CMP:     if (isFinal)     stateNext = DONE;
            DONE:    if (result_ready) stateNext = IDLE;
            default: stateNext = IDLE;
         endcase
      end
   end

   always_comb begin
      start_ready  = (state == IDLE);
      busy         = (state != IDLE);
      result_valid = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aReg      <= '0;
         bReg      <= '0;
         f3Reg     <= '0;
         idx       <= '0;
         BrEq      <= 1'b0;
         BrLT      <= 1'b0;
         BrTaken   <= 1'b0;
         BrIllegal <= 1'b0;
      end else begin
         if (accept) begin
            aReg  <= A_in;
            bReg  <= B_in;
            f3Reg <= funct3;
         end
         if (accept || flush || finishCmp) idx <= '0;
         else if (state == CMP)            idx <= idx + 1'b1;
         if (finishCmp) begin
            BrEq      <= resEq;
            BrLT      <= resLT;
            BrTaken   <= takenNext;
            BrIllegal <= illNext;
         end
      end
   end

endmodule

// File: tb/tb_branch_comp_seq.sv
// Directed bench for branch_comp_seq at XLEN=32, CHUNK=8; expected latency follows BRANCH_COMP_EARLY_EXIT_EN.
module tb_branch_comp_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        start_valid = 1'b0;
   logic        start_ready;
   logic [31:0] A_in = '0;
   logic [31:0] B_in = '0;
   logic [2:0]  funct3 = '0;
   logic        result_valid;
   logic        result_ready = 1'b0;
   logic        BrEq, BrLT, BrTaken, BrIllegal, busy;

   int tests = 0;
   int fails = 0;

`ifdef BRANCH_COMP_EARLY_EXIT_EN
   localparam int MSB_LAT = 1;
`else
   localparam int MSB_LAT = 4;
`endif

   branch_comp_seq #(.XLEN(32), .CHUNK(8)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .start_valid(start_valid), .start_ready(start_ready),
      .A_in(A_in), .B_in(B_in), .funct3(funct3),
      .result_valid(result_valid), .result_ready(result_ready),
      .BrEq(BrEq), .BrLT(BrLT), .BrTaken(BrTaken), .BrIllegal(BrIllegal),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      funct3 = f3; A_in = a; B_in = b; start_valid = 1'b1;
      @(posedge clk);
      #1 start_valid = 1'b0;
   endtask

   task automatic waitResult(input string tag, output int lat);
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (result_valid) break;
      end
      if (!result_valid) chk({tag, ".timeout"}, 32'(result_valid), 32'd1);
   endtask

   task automatic handshake();
      result_ready = 1'b1;
      @(posedge clk);
      #1 result_ready = 1'b0;
   endtask

   task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int expLat, input logic expEq,
                        input logic expLT, input logic expTaken, input logic expIll);
      int lat;
      issue(f3, a, b);
      waitResult(tag, lat);
      chk({tag, ".lat"},     32'(lat),         32'(expLat));
      chk({tag, ".eq"},      32'(BrEq),        32'(expEq));
      chk({tag, ".lt"},      32'(BrLT),        32'(expLT));
      chk({tag, ".taken"},   32'(BrTaken),     32'(expTaken));
      chk({tag, ".illegal"}, 32'(BrIllegal),   32'(expIll));
      chk({tag, ".sready"},  32'(start_ready), 32'd0);
      handshake();
   endtask

   initial begin
      int  lat;
      logic sawRv;

      // Reset state
      #2;
      chk("rst.rvalid",  32'(result_valid), 32'd0);
      chk("rst.eq",      32'(BrEq),         32'd0);
      chk("rst.taken",   32'(BrTaken),      32'd0);
      chk("rst.illegal", 32'(BrIllegal),    32'd0);
      chk("rst.busy",    32'(busy),         32'd0);
      chk("rst.sready",  32'(start_ready),  32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed compares
      runOp("beq_eq",   3'b000, 32'h12345678, 32'h12345678, 4,       1'b1, 1'b0, 1'b1, 1'b0);
      runOp("blt_neg",  3'b100, 32'hFFFFFFFF, 32'h00000001, MSB_LAT, 1'b0, 1'b1, 1'b1, 1'b0);
      runOp("bltu",     3'b110, 32'hFFFFFFFF, 32'h00000001, MSB_LAT, 1'b0, 1'b0, 1'b0, 1'b0);
      runOp("bgeu",     3'b111, 32'hFFFFFFFF, 32'h00000001, MSB_LAT, 1'b0, 1'b0, 1'b1, 1'b0);
      runOp("bge_lo",   3'b101, 32'h00000010, 32'h00000020, 4,       1'b0, 1'b1, 1'b0, 1'b0);
      runOp("illegal",  3'b010, 32'h00000001, 32'h00000002, 4,       1'b0, 1'b1, 1'b0, 1'b1);
      runOp("bne_midc", 3'b001, 32'h00120000, 32'h00130000, (MSB_LAT == 1) ? 2 : 4,
            1'b0, 1'b1, 1'b1, 1'b0);

      // Consumer stalls for 5 cycles
      issue(3'b001, 32'h5, 32'h5);
      waitResult("stall", lat);
      chk("stall.lat", 32'(lat), 32'd4);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("stall.rvalid", 32'(result_valid), 32'd1);
         chk("stall.eq",     32'(BrEq),         32'd1);
         chk("stall.taken",  32'(BrTaken),      32'd0);
         chk("stall.sready", 32'(start_ready),  32'd0);
      end
      handshake();
      @(negedge clk);
      chk("stall.post_sready", 32'(start_ready),  32'd1);
      chk("stall.post_rvalid", 32'(result_valid), 32'd0);

      // Flush in the second CMP cycle
      issue(3'b000, 32'h0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk("flush.busy_before", 32'(busy), 32'd1);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush.busy",   32'(busy),         32'd0);
      chk("flush.sready", 32'(start_ready),  32'd1);
      sawRv = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (result_valid) sawRv = 1'b1;
      end
      chk("flush.no_rvalid", 32'(sawRv), 32'd0);

      // Asynchronous reset mid-compare
      issue(3'b000, 32'h0, 32'h0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst.rvalid", 32'(result_valid), 32'd0);
      chk("arst.eq",     32'(BrEq),         32'd0);
      chk("arst.lt",     32'(BrLT),         32'd0);
      chk("arst.taken",  32'(BrTaken),      32'd0);
      chk("arst.busy",   32'(busy),         32'd0);
      chk("arst.sready", 32'(start_ready),  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("arst.sready_rel", 32'(start_ready), 32'd1);
      runOp("bne_after", 3'b001, 32'h1, 32'h2, 4, 1'b0, 1'b1, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
